// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcode values,
// instruction word layout and FSM state encoding.
package alu_issue_ctrl_pkg;

  // ALU_Sel opcodes; 0 is the NOP that never reaches the ALU
  localparam logic [7:0] OP_NOP   = 8'd0;
  localparam logic [7:0] OP_ADD   = 8'd1;
  localparam logic [7:0] OP_SUB   = 8'd2;
  localparam logic [7:0] OP_AND   = 8'd3;
  localparam logic [7:0] OP_OR    = 8'd4;
  localparam logic [7:0] OP_XOR   = 8'd5;
  localparam logic [7:0] OP_PASSB = 8'd6;

  // Instruction word: [31:24] sel, [23:20] rd, [19:16] rs1, [15:12] rs2,
  // [11] imm_en, [10:0] imm11
  typedef struct packed {
    logic [7:0]  sel;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        imm_en;
    logic [10:0] imm11;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic is_nop(input logic [7:0] sel);
    return sel == OP_NOP;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// General-purpose register file: NREG x DW, two combinational read ports,
// a debug read port and one synchronous write port. r0 and indices at or
// above NREG read as zero and ignore writes.
module alu_issue_ctrl_regfile #(
  parameter int unsigned NREG = 16,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    ra1,
  output logic [DW-1:0] rd1,
  input  logic [3:0]    ra2,
  output logic [DW-1:0] rd2,
  input  logic [3:0]    dbg_idx,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [3:0]    wa,
  input  logic [DW-1:0] wd
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  function automatic logic live_idx(input logic [3:0] idx);
    return (idx != 4'd0) && ({28'd0, idx} < NREG);
  endfunction

  // Combinational reads; zero for r0 and out-of-range indices
  always_comb begin
    rd1      = live_idx(ra1)     ? mem_q[ra1[AW-1:0]]     : '0;
    rd2      = live_idx(ra2)     ? mem_q[ra2[AW-1:0]]     : '0;
    dbg_data = live_idx(dbg_idx) ? mem_q[dbg_idx[AW-1:0]] : '0;
  end

  // Next-state of the storage: apply the single write port
  always_comb begin
    mem_d = mem_q;
    if (we && live_idx(wa)) begin
      mem_d[wa[AW-1:0]] = wd;
    end
  end

  // Storage registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the combinational ALU: accepts one
// instruction at a time, reads operands, drives the ALU, captures the
// result and writes it back to the register file and carry flag.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 16,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [31:0]   instr,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  output logic [7:0]    ALU_Sel,
  input  logic [DW-1:0] ALU_Out,
  input  logic          CarryOut,
  output logic          wb_valid,
  output logic [3:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          carry_flag,
  input  logic [3:0]    dbg_idx,
  output logic [DW-1:0] dbg_data
);

  state_e        state_q, state_d;
  instr_t        instr_q, instr_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [7:0]    alu_sel_q, alu_sel_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          carry_hold_q, carry_hold_d;
  logic          carry_q, carry_d;

  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [DW-1:0] imm_ext;

  alu_issue_ctrl_regfile #(
    .NREG(NREG),
    .DW  (DW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra1     (instr_q.rs1),
    .rd1     (rs1_data),
    .ra2     (instr_q.rs2),
    .rd2     (rs2_data),
    .dbg_idx (dbg_idx),
    .dbg_data(dbg_data),
    .we      (wb_valid),
    .wa      (instr_q.rd),
    .wd      (wb_data_q)
  );

  // Output decode from the registered state
  always_comb begin
    imm_ext     = {{(DW-11){instr_q.imm11[10]}}, instr_q.imm11};
    instr_ready = rst_n && (state_q == ST_IDLE);
    wb_valid    = (state_q == ST_WB);
    wb_rd       = instr_q.rd;
    wb_data     = wb_data_q;
    carry_flag  = carry_q;
    ALU_A       = alu_a_q;
    ALU_B       = alu_b_q;
    ALU_Sel     = alu_sel_q;
  end

  // Next-state and datapath register updates for IDLE->READ->EXEC->WB
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    wb_data_d    = wb_data_q;
    carry_hold_d = carry_hold_q;
    carry_d      = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_d = instr_t'(instr);
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // A NOP retires here without touching the ALU drive
        if (is_nop(instr_q.sel)) begin
          state_d = ST_IDLE;
        end else begin
          alu_a_d   = rs1_data;
          alu_b_d   = instr_q.imm_en ? imm_ext : rs2_data;
          alu_sel_d = instr_q.sel;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wb_data_d    = ALU_Out;
        carry_hold_d = CarryOut;
        state_d      = ST_WB;
      end
      ST_WB: begin
        carry_d = carry_hold_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      wb_data_q    <= '0;
      carry_hold_q <= 1'b0;
      carry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      wb_data_q    <= wb_data_d;
      carry_hold_q <= carry_hold_d;
      carry_q      <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl. Two instances share the stimulus:
// u16 (NREG=16) and u8 (NREG=8, used for out-of-range index behaviour).
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [3:0]  dbg_idx;

  logic        rdy16, rdy8, c16, c8, wbv16, wbv8, cf16, cf8;
  logic [31:0] a16, b16, a8, b8, o16, o8, wbd16, wbd8, dd16, dd8;
  logic [7:0]  s16, s8;
  logic [3:0]  wbrd16, wbrd8;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] a8_exec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] s);
    case (s)
      8'd1:    return {1'b0, a} + {1'b0, b};
      8'd3:    return {1'b0, a & b};
      8'd4:    return {1'b0, a | b};
      8'd5:    return {1'b0, a ^ b};
      default: return '0;
    endcase
  endfunction

  assign {c16, o16} = alu_model(a16, b16, s16);
  assign {c8, o8}   = alu_model(a8, b8, s8);

  alu_issue_ctrl #(.NREG(16), .DW(32)) u16 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(rdy16),
    .instr(instr), .ALU_A(a16), .ALU_B(b16), .ALU_Sel(s16), .ALU_Out(o16),
    .CarryOut(c16), .wb_valid(wbv16), .wb_rd(wbrd16), .wb_data(wbd16),
    .carry_flag(cf16), .dbg_idx(dbg_idx), .dbg_data(dd16)
  );

  alu_issue_ctrl #(.NREG(8), .DW(32)) u8 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(rdy8),
    .instr(instr), .ALU_A(a8), .ALU_B(b8), .ALU_Sel(s8), .ALU_Out(o8),
    .CarryOut(c8), .wb_valid(wbv8), .wb_rd(wbrd8), .wb_data(wbd8),
    .carry_flag(cf8), .dbg_idx(dbg_idx), .dbg_data(dd8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] sel, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic imm_en, input logic [10:0] imm11);
    return {sel, rd, rs1, rs2, imm_en, imm11};
  endfunction

  task automatic chk_reg(input string tag, input logic [3:0] idx,
                         input logic [31:0] exp16, input logic [31:0] exp8);
    dbg_idx = idx;
    #1;
    chk({tag, "_dbg16"}, dd16, exp16);
    chk({tag, "_dbg8"}, dd8, exp8);
  endtask

  // Issue one instruction and watch the four cycles after the handshake
  task automatic run_instr(input logic [31:0] w, input logic exp_wb,
                           input logic [3:0] exp_rd, input logic [31:0] exp_data,
                           input string tag);
    int hs = -1;
    int n16 = 0, n8 = 0, at16 = -1;
    logic [3:0]  rd16_s = '0, rd8_s = '0;
    logic [31:0] d16_s = '0, d8_s = '0;
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 10 && hs < 0; i++) begin
      @(negedge clk);
      if (rdy16) hs = cyc;
    end
    if (hs < 0) begin
      chk({tag, "_handshake"}, 32'(rdy16), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 2) a8_exec = a8;
      if (wbv16) begin n16++; at16 = cyc - hs; rd16_s = wbrd16; d16_s = wbd16; end
      if (wbv8)  begin n8++;  rd8_s = wbrd8; d8_s = wbd8; end
    end
    chk({tag, "_wbcnt16"}, 32'(n16), 32'(exp_wb));
    chk({tag, "_wbcnt8"}, 32'(n8), 32'(exp_wb));
    if (exp_wb) begin
      chk({tag, "_latency"}, 32'(at16), 32'd3);
      chk({tag, "_rd16"}, 32'(rd16_s), 32'(exp_rd));
      chk({tag, "_data16"}, d16_s, exp_data);
      chk({tag, "_rd8"}, 32'(rd8_s), 32'(exp_rd));
      chk({tag, "_data8"}, d8_s, exp_data);
    end
  endtask

  initial begin
    logic [31:0] w [3];
    int hs [3];
    int k;
    int nwb;
    logic got;

    rst_n = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dbg_idx = '0;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(rdy16), 32'd0);
    chk("rst_wbv", 32'(wbv16), 32'd0);
    chk("rst_alu_a", a16, 32'd0);
    chk("rst_alu_sel", 32'(s16), 32'd0);
    chk("rst_carry", 32'(cf16), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready16", 32'(rdy16), 32'd1);
    chk("rel_ready8", 32'(rdy8), 32'd1);

    // Immediate load: r1 = 0 + sext(0x7FF)
    run_instr(mk(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1, 11'h7FF), 1'b1, 4'd1, 32'hFFFF_FFFF, "immld");
    chk_reg("immld_r1", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Carry: r2 = r1 + 1 wraps to 0 with carry out
    run_instr(mk(OP_ADD, 4'd2, 4'd1, 4'd0, 1'b1, 11'h001), 1'b1, 4'd2, 32'h0, "carry");
    chk("carry_flag16", 32'(cf16), 32'd1);
    chk("carry_flag8", 32'(cf8), 32'd1);

    // NOP: no write-back, carry unchanged, rd untouched
    run_instr(mk(OP_NOP, 4'd7, 4'd1, 4'd0, 1'b1, 11'h005), 1'b0, 4'd0, 32'h0, "nop");
    chk("nop_carry", 32'(cf16), 32'd1);
    chk_reg("nop_r7", 4'd7, 32'h0, 32'h0);

    // r0 protection: result r1 ^ 0x123 goes nowhere
    run_instr(mk(OP_XOR, 4'd0, 4'd1, 4'd0, 1'b1, 11'h123), 1'b1, 4'd0, 32'hFFFF_FEDC, "r0wr");
    chk_reg("r0wr_r0", 4'd0, 32'h0, 32'h0);
    chk("r0wr_carry", 32'(cf16), 32'd0);

    // Back-to-back with instr_valid held high
    w[0] = mk(OP_ADD, 4'd4, 4'd1, 4'd0, 1'b1, 11'h002);  // r4 = 1
    w[1] = mk(OP_XOR, 4'd5, 4'd4, 4'd0, 1'b1, 11'h0F0);  // r5 = 0xF1
    w[2] = mk(OP_OR,  4'd6, 4'd5, 4'd1, 1'b0, 11'h000);  // r6 = 0xFFFFFFFF
    hs = '{-1, -1, -1};
    k = 0;
    instr = w[0];
    instr_valid = 1'b1;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (rdy16) begin
        hs[k] = cyc;
        k++;
        @(posedge clk);
        #1;
        if (k < 3) instr = w[k];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);
    chk("b2b_gap01", 32'(hs[1] - hs[0]), 32'd4);
    chk("b2b_gap12", 32'(hs[2] - hs[1]), 32'd4);
    repeat (4) @(negedge clk);
    chk_reg("b2b_r4", 4'd4, 32'h1, 32'h1);
    chk_reg("b2b_r5", 4'd5, 32'hF1, 32'hF1);
    chk_reg("b2b_r6", 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_carry", 32'(cf16), 32'd0);

    // Out-of-range indices on the NREG=8 instance: rd=9, rs1=12
    run_instr(mk(OP_ADD, 4'd9, 4'd12, 4'd0, 1'b1, 11'h003), 1'b1, 4'd9, 32'h3, "oor");
    chk("oor_alu_a8", a8_exec, 32'h0);
    chk_reg("oor_r9", 4'd9, 32'h3, 32'h0);
    chk_reg("oor_r1", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_reg("oor_r4", 4'd4, 32'h1, 32'h1);

    // Reset asserted during EXEC aborts the instruction
    dbg_idx = 4'd1;
    instr = mk(OP_ADD, 4'd3, 4'd1, 4'd0, 1'b1, 11'h005);
    instr_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = rdy16;
    end
    chk("midrst_handshake", 32'(got), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre_alu_a", a16, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    chk("midrst_alu_a", a16, 32'h0);
    chk("midrst_alu_b", b16, 32'h0);
    chk("midrst_alu_sel", 32'(s16), 32'd0);
    chk("midrst_ready", 32'(rdy16), 32'd0);
    chk("midrst_wbv", 32'(wbv16), 32'd0);
    chk("midrst_wbd", wbd16, 32'h0);
    chk("midrst_wbrd", 32'(wbrd16), 32'd0);
    chk("midrst_dbg_r1", dd16, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", 32'(rdy16), 32'd1);
    nwb = 0;
    repeat (6) begin
      @(negedge clk);
      if (wbv16 || wbv8) nwb++;
    end
    chk("midrst_no_wb", 32'(nwb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
